// File: rtl/serial_cla_subtractor.sv
// Multi-cycle unsigned subtractor: diff = a - b - borrow_in, one 4-bit borrow-lookahead slice per clock.
// Optional `SUB_SAT_EN: clamp diff to zero when the final borrow is set.
module serial_cla_subtractor #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned NSLICE = WIDTH / 4;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              borrow_q, borrow_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              borrow_out_q, borrow_out_d;

  logic [3:0]        x_c, y_c, g_c, p_c, s_c;
  logic [4:0]        c_c;
  logic [WIDTH-1:0]  res_next_c;

  // Borrow-lookahead slice on the low nibble of the shifting operands (a + ~b + ~borrow).
  always_comb begin
    x_c    = a_q[3:0];
    y_c    = ~b_q[3:0];
    g_c    = x_c & y_c;
    p_c    = x_c ^ y_c;
    c_c[0] = ~borrow_q;
    c_c[1] = g_c[0] | (p_c[0] & c_c[0]);
    c_c[2] = g_c[1] | (p_c[1] & g_c[0]) | (p_c[1] & p_c[0] & c_c[0]);
    c_c[3] = g_c[2] | (p_c[2] & g_c[1]) | (p_c[2] & p_c[1] & g_c[0])
           | (p_c[2] & p_c[1] & p_c[0] & c_c[0]);
    c_c[4] = g_c[3] | (p_c[3] & g_c[2]) | (p_c[3] & p_c[2] & g_c[1])
           | (p_c[3] & p_c[2] & p_c[1] & g_c[0])
           | (p_c[3] & p_c[2] & p_c[1] & p_c[0] & c_c[0]);
    s_c    = p_c ^ c_c[3:0];
    // Slice results enter at the top so the LSB slice lands at bit 0 after NSLICE shifts.
    res_next_c = (res_q >> 4) | (WIDTH'(s_c) << (WIDTH - 4));
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    a_d          = a_q;
    b_d          = b_q;
    borrow_d     = borrow_q;
    res_d        = res_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_BUSY;
          busy_d   = 1'b1;
          a_d      = a;
          b_d      = b;
          borrow_d = borrow_in;
          idx_d    = '0;
          res_d    = '0;
        end
      end
      S_BUSY: begin
        a_d      = a_q >> 4;
        b_d      = b_q >> 4;
        borrow_d = ~c_c[4];
        res_d    = res_next_c;
        idx_d    = idx_q + 1'b1;
        if (idx_q == IDXW'(NSLICE - 1)) begin
          state_d      = S_IDLE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          idx_d        = '0;
          borrow_out_d = ~c_c[4];
`ifdef SUB_SAT_EN
          diff_d       = c_c[4] ? res_next_c : '0;
`else
          diff_d       = res_next_c;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      borrow_q     <= 1'b0;
      res_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      a_q          <= a_d;
      b_q          <= b_d;
      borrow_q     <= borrow_d;
      res_q        <= res_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule
